// File: rtl/lsc_i2c_pkg.sv
// Shared definitions for the lsc_i2cs_16 I2C register-access target.
//   state_t           : target FSM states
//   I2C_ACK/I2C_NACK  : SDA levels driven during the acknowledge bit
//   DEV_ADDR_DEFAULT  : default 7-bit target address
package lsc_i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StDack,
        StOfsh,
        StOfsl,
        StWdat,
        StRdat,
        StRack,
        StWait
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h24;

endpackage

// File: rtl/lsc_i2c_filt.sv
// Two-flop synchronizer followed by a glitch filter and edge flags for one bus line.
//   clk, reset : clock and synchronous active-high reset
//   raw_i      : raw bus level
//   level_o    : filtered level (resets to 1, the idle bus level)
//   rise_o     : one-cycle flag, asserted in the cycle level_o becomes 1
//   fall_o     : one-cycle flag, asserted in the cycle level_o becomes 0
module lsc_i2c_filt #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CntW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_LEN - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            rise_q, fall_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // A new level is accepted only after FILT_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/lsc_i2cs_16.sv
// I2C target with a 16-bit register pointer and a simple register strobe interface.
//   clk, reset          : 48 MHz clock, synchronous active-high reset
//   scl_in, sda_in      : raw bus levels
//   scl_out             : always 1 (no clock stretching)
//   sda_out             : 0 pulls SDA low, 1 releases it
//   reg_addr            : register pointer, kept across transactions
//   reg_wr, reg_wdata   : one-cycle write strobe and data
//   reg_rd, reg_rdata   : one-cycle read strobe; reg_rdata valid the cycle after
//   busy                : high from an address match until STOP
module lsc_i2cs_16
    import lsc_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_out,
    output logic        sda_out,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    lsc_i2c_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    lsc_i2c_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;      // state to enter once our ACK bit is released
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        sda_q, sda_d;
    logic        busy_q, busy_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        cap_q;             // reg_rdata is valid this cycle
    logic [7:0]  wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sda_d   = sda_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        wdata_d = wdata_q;

        if (wr_q) addr_d = addr_q + 16'd1;
        if (cap_q) shreg_d = reg_rdata;

        if (stop) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            sda_d   = I2C_NACK;
            cnt_d   = '0;
        end else if (start) begin
            state_d = StDev;
            sda_d   = I2C_NACK;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StDev, StOfsh, StOfsl, StWdat: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shreg_d = {shreg_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        sda_d   = I2C_ACK;
                        state_d = StDack;
                        case (state_q)
                            StDev: begin
                                if (shreg_q[7:1] != DEV_ADDR) begin
                                    sda_d   = I2C_NACK;
                                    state_d = StWait;
                                end else begin
                                    busy_d = 1'b1;
                                    if (shreg_q[0]) begin
                                        ret_d = StRdat;
                                        rd_d  = 1'b1;
                                    end else begin
                                        ret_d = StOfsh;
                                    end
                                end
                            end
                            StOfsh: begin
                                addr_d = {shreg_q, addr_q[7:0]};
                                ret_d  = StOfsl;
                            end
                            StOfsl: begin
                                addr_d = {addr_q[15:8], shreg_q};
                                ret_d  = StWdat;
                            end
                            default: begin
                                wr_d    = 1'b1;
                                wdata_d = shreg_q;
                                ret_d   = StWdat;
                            end
                        endcase
                    end
                end
                StDack: begin
                    if (scl_fall) begin
                        state_d = ret_q;
                        if (ret_q == StRdat) begin
                            // Releasing the ACK and driving the read MSB share this edge.
                            sda_d   = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                            cnt_d   = 4'd1;
                        end else begin
                            sda_d = I2C_NACK;
                            cnt_d = '0;
                        end
                    end
                end
                StRdat: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_d   = I2C_NACK;
                            cnt_d   = '0;
                            state_d = StRack;
                        end else begin
                            sda_d   = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                StRack: begin
                    // Fetch on the ACK rising edge so data is ready by the next falling edge.
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) begin
                            addr_d  = addr_q + 16'd1;
                            rd_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = StRdat;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StIdle, StWait: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ret_q   <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cap_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cap_q   <= rd_q;
            wdata_q <= wdata_d;
        end
    end

    assign scl_out   = 1'b1;
    assign sda_out   = sda_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign busy      = busy_q;

endmodule

// File: doc/lsc_i2cs_16.md
LSC_I2CS_16 -- requirements
Module: lsc_i2cs_16

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h24, the 7-bit target address answered.
REQ-002 SHALL have parameter FILT_LEN, default 3, the number of consecutive clk samples a line level must hold to be accepted.
REQ-003 SHALL have port clk, input, 1 bit: the single 48 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports scl_in and sda_in, input, 1 bit each: raw bus levels.
REQ-006 SHALL have port scl_out, output, 1 bit: tied to 1, so SCL is never stretched.
REQ-007 SHALL have port sda_out, output, 1 bit: 0 drives the line low, 1 releases it.
REQ-008 SHALL have port reg_addr, output, 16 bits: the register pointer.
REQ-009 SHALL have ports reg_wr, output, 1 bit, and reg_wdata, output, 8 bits: a one-cycle write strobe with its data.
REQ-010 SHALL have ports reg_rd, output, 1 bit, and reg_rdata, input, 8 bits: a one-cycle read strobe; data is valid on the cycle after the strobe.
REQ-011 SHALL have port busy, output, 1 bit: high from an address-matched START until the STOP.

Function
REQ-012 SHALL pass scl_in and sda_in through a 2-flop synchronizer, then the FILT_LEN glitch filter; all decoding uses the filtered levels.
REQ-013 SHALL decode events from the filtered levels:
- START/Sr: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Data bits are sampled on the SCL rising edge; sda_out changes only on the SCL falling edge.
REQ-014 SHALL implement states IDLE, DEV, DACK, OFSH, OFSL, WDAT, RDAT, RACK, WAIT.
REQ-015 SHALL enter DEV on START/Sr from any state, resetting the bit counter, including mid-byte.
REQ-016 SHALL enter IDLE and drop busy on STOP from any state.
REQ-017 SHALL, in DEV after 8 bits:
- Match {addr, rw} against DEV_ADDR, pull SDA low for the ACK bit, then go to OFSH (rw=0) or RDAT (rw=1).
- On a mismatch, leave SDA released and go to WAIT.
REQ-018 SHALL, for a write (OFSH, OFSL, WDAT):
- OFSH loads reg_addr[15:8]; OFSL loads reg_addr[7:0]; each byte is ACKed.
- Each WDAT byte is ACKed and pulses reg_wr with reg_wdata on the 8th-bit SCL falling edge, then increments reg_addr on the next cycle.
REQ-019 SHALL, for a read:
- On the ACK falling edge of the address byte, pulse reg_rd at the current reg_addr and capture reg_rdata 1 cycle later.
- Shift the byte out MSB first starting at the falling edge that releases the ACK.
REQ-020 SHALL, in RACK:
- On a master ACK (SDA=0), increment reg_addr, pulse reg_rd, and return to RDAT.
- On a NACK, release SDA and go to WAIT.
REQ-021 SHALL wrap reg_addr from 16'hFFFF to 16'h0000.
REQ-022 SHALL retain reg_addr across transactions, so that write-offset followed by Sr-read performs a random read.
REQ-023 SHALL, in WAIT, ignore all bits until START/Sr or STOP.
REQ-024 SHALL produce at most one reg_wr or reg_rd per byte, and never both in the same cycle.

Reset
REQ-025 SHALL, while reset is asserted, set: state=IDLE, sda_out=1, scl_out=1, reg_addr=0, reg_wr=0, reg_rd=0, reg_wdata=0, busy=0, and filter outputs=1.
REQ-026 SHALL, on reset asserted mid-transfer, release SDA on the next clk edge and then wait for a new START.

Structure
REQ-027 SHALL place the state encoding, the I2C_ACK/I2C_NACK constants and the default DEV_ADDR in the shared package lsc_i2c_pkg.
REQ-028 SHALL use one sub-module, lsc_i2c_filt (synchronizer plus filter plus edge flags), instantiated once each for SCL and SDA.

Verification
REQ-029 SHALL cover a write: START, 0x48, 0x30, 0x10, 0xAB, 0xCD, STOP -> all ACKed; reg_wr at 0x3010=0xAB and 0x3011=0xCD; final reg_addr=0x3012.
REQ-030 SHALL cover a random read: START, 0x48, 0x00, 0x00, Sr, 0x49; model returns 0x01 then 0x62; master ACKs, then NACKs -> bytes 0x01 and 0x62 on SDA; reg_rd at 0x0000 and 0x0001; released after the NACK.
REQ-031 SHALL cover an address mismatch: START, 0x4A, then 3 bytes -> sda_out stays 1 throughout; no strobes; busy stays 0.
REQ-032 SHALL cover wrap: write offset 0xFFFF, data 0x11, 0x22 -> writes at 0xFFFF and 0x0000.
REQ-033 SHALL cover an abort: START inserted after 4 bits of OFSL -> new address byte 0x48 is accepted; no reg_wr issued. Reset during RDAT -> sda_out=1 on the next clk edge.
REQ-034 SHALL cover glitches: a 2-cycle SDA glitch while SCL is high, with FILT_LEN=3 -> no START/STOP detected; state unchanged.
